// File: rtl/sme_bank_xfer.sv
// rtl/sme_bank_xfer.sv - share-bank <-> memory transfer sequencer
//
// Moves masked shares between data memory and SME share banks 1..SMAX-1 of
// one bank register. One command at a time, one memory transaction in flight.
//
// Ports:
//   g_clk, g_resetn          clock, async active-low reset
//   g_clk_req                clock request while busy or a command is offered
//   flush                    abandon the in-progress command
//   cmd_*                    command handshake and fields (store/reg/addr/count)
//   mem_*                    memory request (req/gnt) and response (recv) ports
//   bank_sel                 bank being accessed (write bank while bank_wen)
//   bank_wen/waddr/wdata     bank write port, registered
//   bank_read/raddr/rdata    bank read port, rdata combinational from sel/raddr
//   rsp_valid, rsp_error     one-cycle completion pulse and bus-error flag
module sme_bank_xfer #(
    parameter int XLEN = 32,
    parameter int SMAX = 4
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    output logic            g_clk_req,
    input  logic            flush,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_store,
    input  logic [3:0]      cmd_reg,
    input  logic [XLEN-1:0] cmd_addr,
    input  logic [3:0]      cmd_count,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_recv,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_error,
    output logic [3:0]      bank_sel,
    output logic            bank_wen,
    output logic [3:0]      bank_waddr,
    output logic [XLEN-1:0] bank_wdata,
    output logic            bank_read,
    output logic [3:0]      bank_raddr,
    input  logic [XLEN-1:0] bank_rdata,
    output logic            rsp_valid,
    output logic            rsp_error
);

    localparam logic [3:0] NMAX = 4'(SMAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      k_q, k_d;
    logic [3:0]      n_q, n_d;
    logic [3:0]      reg_q, reg_d;
    logic [XLEN-1:0] base_q, base_d;
    logic            store_q, store_d;
    logic            flushed_q, flushed_d;
    logic            err_q, err_d;
    logic            bwen_q, bwen_d;
    logic [3:0]      bwsel_q, bwsel_d;
    logic [3:0]      bwaddr_q, bwaddr_d;
    logic [XLEN-1:0] bwdata_q, bwdata_d;

    logic [3:0]      n_clamp;
    logic [XLEN-1:0] beat_off;
    logic            in_req;

    assign n_clamp  = (cmd_count > NMAX) ? NMAX : cmd_count;
    assign beat_off = {{(XLEN-4){1'b0}}, k_q - 4'd1} << 2;
    assign in_req   = (state_q == S_REQ);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        reg_d     = reg_q;
        base_d    = base_q;
        store_d   = store_q;
        flushed_d = flushed_q;
        err_d     = err_q;
        // Bank write is a single-cycle pulse; clear it unless re-armed below.
        bwen_d    = 1'b0;
        bwsel_d   = 4'd0;
        bwaddr_d  = 4'd0;
        bwdata_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    reg_d     = cmd_reg;
                    base_d    = cmd_addr;
                    store_d   = cmd_store;
                    n_d       = n_clamp;
                    k_d       = 4'd1;
                    err_d     = 1'b0;
                    flushed_d = 1'b0;
                    state_d   = (n_clamp == 4'd0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // A grant coinciding with flush is deliberately dropped.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (mem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (mem_recv) begin
                    if (flushed_q || flush) begin
                        flushed_d = 1'b0;
                        state_d   = S_IDLE;
                    end else if (mem_error) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        if (!store_q) begin
                            bwen_d   = 1'b1;
                            bwsel_d  = k_q;
                            bwaddr_d = reg_q;
                            bwdata_d = mem_rdata;
                        end
                        if (k_q == n_q) begin
                            state_d = S_DONE;
                        end else begin
                            k_d     = k_q + 4'd1;
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= S_IDLE;
            k_q       <= 4'd0;
            n_q       <= 4'd0;
            reg_q     <= 4'd0;
            base_q    <= '0;
            store_q   <= 1'b0;
            flushed_q <= 1'b0;
            err_q     <= 1'b0;
            bwen_q    <= 1'b0;
            bwsel_q   <= 4'd0;
            bwaddr_q  <= 4'd0;
            bwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            reg_q     <= reg_d;
            base_q    <= base_d;
            store_q   <= store_d;
            flushed_q <= flushed_d;
            err_q     <= err_d;
            bwen_q    <= bwen_d;
            bwsel_q   <= bwsel_d;
            bwaddr_q  <= bwaddr_d;
            bwdata_q  <= bwdata_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign g_clk_req  = (state_q != S_IDLE) || cmd_valid;

    assign mem_req    = in_req;
    assign mem_wen    = in_req && store_q;
    assign mem_addr   = in_req ? (base_q + beat_off) : '0;
    assign bank_read  = in_req && store_q;
    assign bank_raddr = bank_read ? reg_q : 4'd0;
    assign mem_wdata  = bank_read ? bank_rdata : '0;

    // A pending load write targets the previous beat's bank, which can
    // overlap the next REQ cycle; loads never read, so the write wins.
    assign bank_sel   = bwen_q ? bwsel_q : (in_req ? k_q : 4'd0);
    assign bank_wen   = bwen_q;
    assign bank_waddr = bwaddr_q;
    assign bank_wdata = bwdata_q;

    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_error  = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_sme_bank_xfer.sv
// tb/tb_sme_bank_xfer.sv - directed self-checking bench for sme_bank_xfer
module tb_sme_bank_xfer;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        g_clk_req;
    logic        flush;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_store;
    logic [3:0]  cmd_reg;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_count;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_recv;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic [3:0]  bank_sel;
    logic        bank_wen;
    logic [3:0]  bank_waddr;
    logic [31:0] bank_wdata;
    logic        bank_read;
    logic [3:0]  bank_raddr;
    logic [31:0] bank_rdata;
    logic        rsp_valid;
    logic        rsp_error;

    always #5 g_clk = ~g_clk;

    assign bank_rdata = 32'h0000_1000 + {28'h0, bank_sel};

    sme_bank_xfer #(.XLEN(32), .SMAX(4)) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .g_clk_req  (g_clk_req),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_store  (cmd_store),
        .cmd_reg    (cmd_reg),
        .cmd_addr   (cmd_addr),
        .cmd_count  (cmd_count),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_recv   (mem_recv),
        .mem_rdata  (mem_rdata),
        .mem_error  (mem_error),
        .bank_sel   (bank_sel),
        .bank_wen   (bank_wen),
        .bank_waddr (bank_waddr),
        .bank_wdata (bank_wdata),
        .bank_read  (bank_read),
        .bank_raddr (bank_raddr),
        .bank_rdata (bank_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_error  (rsp_error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    int          gnt_delay  = 0;
    int          recv_delay = 0;
    int          err_beat   = -1;
    logic [31:0] rd_tab [0:3];

    int          req_cnt = 0;
    logic [31:0] req_addr  [0:7];
    logic [31:0] req_wdata [0:7];
    logic        req_wen   [0:7];
    logic [3:0]  req_raddr [0:7];
    int          bw_cnt = 0;
    logic [3:0]  bw_sel  [0:7];
    logic [3:0]  bw_addr [0:7];
    logic [31:0] bw_data [0:7];
    int          bw_cyc  [0:7];
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    logic        rsp_err_l = 1'b0;
    int          stab_err = 0;

    initial forever begin
        @(posedge g_clk);
        cyc++;
    end

    // Memory responder and bus monitor, evaluated once per cycle at negedge.
    initial begin : mem_model
        int          wait_cnt;
        int          pend_cnt;
        int          rd_idx;
        logic        prev_pend;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        wait_cnt  = 0;
        pend_cnt  = 0;
        rd_idx    = 0;
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_wdata = '0;
        mem_gnt   = 1'b0;
        mem_recv  = 1'b0;
        mem_error = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge g_clk);
            mem_gnt   = 1'b0;
            mem_recv  = 1'b0;
            mem_error = 1'b0;
            mem_rdata = '0;
            if (!g_resetn) begin
                wait_cnt  = 0;
                pend_cnt  = 0;
                prev_pend = 1'b0;
            end else begin
                if (prev_pend && mem_req &&
                    (mem_addr !== prev_addr || mem_wdata !== prev_wdata))
                    stab_err++;
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        mem_recv  = 1'b1;
                        mem_rdata = rd_tab[rd_idx % 4];
                        mem_error = (rd_idx == err_beat);
                    end
                end else if (mem_req) begin
                    if (wait_cnt < gnt_delay) begin
                        wait_cnt++;
                    end else begin
                        mem_gnt  = 1'b1;
                        wait_cnt = 0;
                        pend_cnt = recv_delay + 1;
                        rd_idx   = req_cnt;
                        if (req_cnt < 8) begin
                            req_addr[req_cnt]  = mem_addr;
                            req_wdata[req_cnt] = mem_wdata;
                            req_wen[req_cnt]   = mem_wen;
                            req_raddr[req_cnt] = bank_raddr;
                        end
                        req_cnt++;
                    end
                end
                prev_pend  = mem_req && !mem_gnt;
                prev_addr  = mem_addr;
                prev_wdata = mem_wdata;
                if (bank_wen) begin
                    if (bw_cnt < 8) begin
                        bw_sel[bw_cnt]  = bank_sel;
                        bw_addr[bw_cnt] = bank_waddr;
                        bw_data[bw_cnt] = bank_wdata;
                        bw_cyc[bw_cnt]  = cyc - t0;
                    end
                    bw_cnt++;
                end
                if (rsp_valid) begin
                    rsp_cnt++;
                    rsp_cyc   = cyc - t0;
                    rsp_err_l = rsp_error;
                end
            end
        end
    end

    task automatic send_cmd(input logic st, input logic [3:0] rg,
                            input logic [31:0] ad, input logic [3:0] cn);
        @(negedge g_clk);
        #1;
        req_cnt  = 0;
        bw_cnt   = 0;
        rsp_cnt  = 0;
        stab_err = 0;
        t0        = cyc;
        cmd_valid = 1'b1;
        cmd_store = st;
        cmd_reg   = rg;
        cmd_addr  = ad;
        cmd_count = cn;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready);
        end
        @(posedge g_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && rsp_cnt == 0; i++) @(posedge g_clk);
        checks++;
        if (rsp_cnt == 0) begin
            errors++;
            $display("FAIL rsp_timeout got none exp rsp_valid within %0d cycles", budget);
        end
        repeat (2) @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset();
        g_resetn  = 1'b0;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        cmd_store = 1'b0;
        cmd_reg   = 4'd0;
        cmd_addr  = '0;
        cmd_count = 4'd0;
        repeat (3) @(posedge g_clk);
        #1;
        checks++;
        if ({mem_req, mem_wen, bank_wen, bank_read, rsp_valid, rsp_error, g_clk_req} !== 7'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 0000000",
                     {mem_req, mem_wen, bank_wen, bank_read, rsp_valid, rsp_error, g_clk_req});
        end
        checks++;
        if ({bank_sel, bank_waddr, bank_raddr} !== 12'h0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || bank_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_buses got sel %h addr %h exp all zero", bank_sel, mem_addr);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_load_basic();
        logic [31:0] exp_d [0:2];
        exp_d[0] = 32'hA1; exp_d[1] = 32'hB2; exp_d[2] = 32'hC3;
        for (int i = 0; i < 3; i++) rd_tab[i] = exp_d[i];
        gnt_delay = 0; recv_delay = 0; err_beat = -1;
        send_cmd(1'b0, 4'd5, 32'h100, 4'd3);
        wait_done(40);
        checks++;
        if (req_cnt != 3 || bw_cnt != 3) begin
            errors++;
            $display("FAIL load_counts got req %0d wr %0d exp 3 3", req_cnt, bw_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_addr[i] !== 32'h100 + 32'(4 * i) || req_wen[i] !== 1'b0) begin
                errors++;
                $display("FAIL load_addr%0d got %h wen %b exp %h wen 0",
                         i, req_addr[i], req_wen[i], 32'h100 + 32'(4 * i));
            end
            checks++;
            if (bw_sel[i] !== 4'(i + 1) || bw_addr[i] !== 4'd5 || bw_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL load_bankwr%0d got sel %0d reg %0d data %h exp sel %0d reg 5 data %h",
                         i, bw_sel[i], bw_addr[i], bw_data[i], i + 1, exp_d[i]);
            end
        end
        checks++;
        if (rsp_cyc != 7 || rsp_err_l !== 1'b0 || bw_cyc[2] != 7) begin
            errors++;
            $display("FAIL load_timing got rsp cyc %0d err %b lastwr cyc %0d exp 7 0 7",
                     rsp_cyc, rsp_err_l, bw_cyc[2]);
        end
    endtask

    task automatic test_store_delay();
        gnt_delay = 3; recv_delay = 0; err_beat = -1;
        send_cmd(1'b1, 4'd2, 32'h200, 4'd2);
        wait_done(60);
        checks++;
        if (req_cnt != 2 || bw_cnt != 0) begin
            errors++;
            $display("FAIL store_counts got req %0d wr %0d exp 2 0", req_cnt, bw_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (req_addr[i] !== 32'h200 + 32'(4 * i) || req_wdata[i] !== 32'h1001 + 32'(i) ||
                req_wen[i] !== 1'b1 || req_raddr[i] !== 4'd2) begin
                errors++;
                $display("FAIL store_beat%0d got %h@%h wen %b raddr %0d exp %h@%h wen 1 raddr 2",
                         i, req_wdata[i], req_addr[i], req_wen[i], req_raddr[i],
                         32'h1001 + 32'(i), 32'h200 + 32'(4 * i));
            end
        end
        checks++;
        if (stab_err != 0 || rsp_cyc != 11) begin
            errors++;
            $display("FAIL store_hold got unstable %0d rsp cyc %0d exp 0 11", stab_err, rsp_cyc);
        end
        gnt_delay = 0;
    endtask

    task automatic test_error();
        rd_tab[0] = 32'h11; rd_tab[1] = 32'h22; rd_tab[2] = 32'h33;
        gnt_delay = 0; recv_delay = 0; err_beat = 1;
        send_cmd(1'b0, 4'd3, 32'h40, 4'd3);
        wait_done(40);
        checks++;
        if (req_cnt != 2 || bw_cnt != 1 || bw_sel[0] !== 4'd1 || bw_data[0] !== 32'h11) begin
            errors++;
            $display("FAIL err_abort got req %0d wr %0d sel %0d data %h exp 2 1 1 00000011",
                     req_cnt, bw_cnt, bw_sel[0], bw_data[0]);
        end
        checks++;
        if (rsp_err_l !== 1'b1 || rsp_cyc != 5) begin
            errors++;
            $display("FAIL err_rsp got err %b cyc %0d exp 1 5", rsp_err_l, rsp_cyc);
        end
        err_beat = -1;
    endtask

    task automatic test_wrap();
        send_cmd(1'b0, 4'd1, 32'hFFFF_FFFC, 4'd2);
        wait_done(40);
        checks++;
        if (req_cnt != 2 || req_addr[0] !== 32'hFFFF_FFFC || req_addr[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr got %0d reqs %h %h exp 2 fffffffc 00000000",
                     req_cnt, req_addr[0], req_addr[1]);
        end
    endtask

    task automatic test_count_edges();
        send_cmd(1'b0, 4'd4, 32'h300, 4'd0);
        wait_done(10);
        checks++;
        if (rsp_cyc != 1 || req_cnt != 0 || rsp_err_l !== 1'b0) begin
            errors++;
            $display("FAIL count0 got rsp cyc %0d reqs %0d err %b exp 1 0 0",
                     rsp_cyc, req_cnt, rsp_err_l);
        end
        send_cmd(1'b0, 4'd4, 32'h300, 4'd9);
        wait_done(40);
        checks++;
        if (req_cnt != 3 || bw_cnt != 3 || rsp_cyc != 7) begin
            errors++;
            $display("FAIL count9_clamp got reqs %0d wr %0d rsp cyc %0d exp 3 3 7",
                     req_cnt, bw_cnt, rsp_cyc);
        end
    endtask

    task automatic test_flush_req();
        send_cmd(1'b0, 4'd6, 32'h500, 4'd2);
        flush = 1'b1;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_req_idle got cmd_ready %b exp 1", cmd_ready);
        end
        repeat (5) @(posedge g_clk);
        #1;
        checks++;
        if (bw_cnt != 0 || rsp_cnt != 0 || req_cnt != 1) begin
            errors++;
            $display("FAIL flush_req_quiet got wr %0d rsp %0d reqs %0d exp 0 0 1",
                     bw_cnt, rsp_cnt, req_cnt);
        end
    endtask

    task automatic test_flush_wait();
        recv_delay = 2;
        send_cmd(1'b0, 4'd1, 32'h600, 4'd3);
        @(posedge g_clk);
        #1;
        flush = 1'b1;
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_busy got cmd_ready %b exp 0", cmd_ready);
        end
        repeat (4) @(posedge g_clk);
        #1;
        checks++;
        if (bw_cnt != 0 || rsp_cnt != 0 || req_cnt != 1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait_end got wr %0d rsp %0d reqs %0d ready %b exp 0 0 1 1",
                     bw_cnt, rsp_cnt, req_cnt, cmd_ready);
        end
        recv_delay = 0;
    endtask

    task automatic test_reset_mid();
        gnt_delay = 5;
        send_cmd(1'b0, 4'd7, 32'h700, 4'd2);
        @(negedge g_clk);
        checks++;
        if (mem_req !== 1'b1 || bank_sel !== 4'd1) begin
            errors++;
            $display("FAIL rst_mid_req got mem_req %b sel %0d exp 1 1", mem_req, bank_sel);
        end
        #1;
        g_resetn = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || bank_sel !== 4'd0 || mem_addr !== 32'h0 || g_clk_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_clear got req %b sel %0d addr %h clkreq %b exp 0 0 0 0",
                     mem_req, bank_sel, mem_addr, g_clk_req);
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release got ready %b req %b exp 1 0", cmd_ready, mem_req);
        end
        gnt_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rd_tab[i] = '0;
        test_reset();
        test_load_basic();
        test_store_delay();
        test_error();
        test_wrap();
        test_count_edges();
        test_flush_req();
        test_flush_wait();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sme_bank_xfer.md
# sme_bank_xfer

Sequencer for moving masked shares between data memory and the SME share banks. It accepts one share-transfer command from the core. A load pulls memory words into banks 1..N of a register. A store reads them out of the banks and writes them to memory. It drives the bank write port (bank_wen/bank_waddr/bank_wdata) and the bank read port (bank_read/bank_rdata) of the SME state block, and it is the master of that interface. Share 0 lives in the GPRs and is never touched by this block.

## Interface
- XLEN, 32, data/address width.
- SMAX, 4, max hardware shares; banks 1..SMAX-1 are addressable.

- g_clk  in  1  global clock.
- g_resetn  in  1  reset, asynchronous, active-low.
- g_clk_req  out  1  high whenever state != IDLE or cmd_valid.
- flush  in  1  discard in-progress command.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_store  in  1  1=store shares to memory, 0=load shares from memory.
- cmd_reg  in  4  bank register index.
- cmd_addr  in  XLEN  base byte address (word aligned).
- cmd_count  in  4  banks to transfer; clamped to SMAX-1.
- mem_req  out  1  memory request valid.
- mem_gnt  in  1  request accepted.
- mem_wen  out  1  write request.
- mem_addr  out  XLEN  request address.
- mem_wdata  out  XLEN  store data.
- mem_recv  in  1  response valid.
- mem_rdata  in  XLEN  load data.
- mem_error  in  1  response carries bus error.
- bank_sel  out  4  bank being accessed (1..SMAX-1); 0 in IDLE.
- bank_wen  out  1  bank write strobe.
- bank_waddr  out  4  bank write register.
- bank_wdata  out  XLEN  bank write data.
- bank_read  out  1  bank read strobe.
- bank_raddr  out  4  bank read register.
- bank_rdata  in  XLEN  bank read data, combinational from bank_sel/bank_raddr.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_error  out  1  qualifies rsp_valid; bus error seen.

## Operation
- States: IDLE, REQ, WAIT, DONE. Registers: k (beat, 1..n), n, reg, base, store, flushed, err.
- IDLE: cmd_ready=1. When cmd_valid:
  - latch fields; n = min(cmd_count, SMAX-1); k=1.
  - If n=0, go to DONE with err=0.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1, mem_wen=store, mem_addr = base + 4*(k-1), modulo 2^XLEN.
  - bank_sel=k.
  - For a store: bank_read=1, bank_raddr=reg, mem_wdata=bank_rdata (combinational).
  - mem_gnt: go to WAIT.
  - mem_req holds with stable address/data until granted.
- WAIT: only one transaction is outstanding. On mem_recv:
  - mem_error=1: err=1, go to DONE; remaining beats are abandoned and no bank write occurs for the errored beat.
  - load, no error: register bank_wen=1, bank_sel=k, bank_waddr=reg, bank_wdata=mem_rdata for exactly the next cycle.
  - k==n: go to DONE. Otherwise k=k+1, go to REQ.
- DONE: rsp_valid=1, rsp_error=err for one cycle; next state is IDLE. There is no rsp backpressure.
- flush handling:
  - IDLE: no effect.
  - REQ: go to IDLE immediately. Any grant in that same cycle is treated as not taken, and the memory side must accept that.
  - WAIT: set flushed, keep waiting for mem_recv, suppress the bank write, then go to IDLE. No rsp_valid is issued.
  - DONE: rsp_valid still issues.
- A new command is accepted only in IDLE, and never in the same cycle as rsp_valid.
- Async reset mid-operation: return to IDLE, all registers and outputs cleared. Any outstanding memory response after reset is ignored, because WAIT is not active.

## Timing
- Reset values: cmd_ready=1 and every other output 0, including bank_sel, addresses and data.
- Zero-wait memory (gnt in REQ cycle, recv the cycle after): each beat takes 2 cycles (REQ, WAIT).
- n-beat command accepted in cycle 0: rsp_valid in cycle 2n+1. The final load bank write coincides with rsp_valid.
- n=0: rsp_valid in cycle 1.
- Bank write lags its mem_recv by exactly 1 cycle. The bank read is combinational within the REQ cycles.

## Test plan
- Load, reg=5, addr=0x100, count=3, zero-wait memory returning 0xA1/0xB2/0xC3:
  - mem_addr is 0x100, 0x104, 0x108.
  - bank_wen pulses to banks 1, 2, 3 (reg 5) with those data.
  - rsp_valid in cycle 7, rsp_error=0.
- Store, reg=2, count=2, bank_rdata model returns 0x1000+bank_sel, gnt delayed 3 cycles per beat:
  - two mem writes of 0x1001@base and 0x1002@base+4.
  - mem_req, address and data held stable while waiting for grant.
- Load, count=3, mem_error on beat 2:
  - only bank 1 is written.
  - no third request is issued.
  - rsp_valid with rsp_error=1.
- Base address 0xFFFFFFFC, count=2 → addresses 0xFFFFFFFC then 0x00000000 (wrap).
- count=0 → rsp_valid next cycle, no mem_req. count=9 with SMAX=4 → exactly 3 beats.
- Flush in WAIT of beat 1 of a load → no bank_wen, no rsp_valid, back in IDLE after mem_recv. Async reset asserted in REQ → outputs 0 immediately, cmd_ready=1 after release.
